// File: rtl/spp_host_seq_pkg.sv
// spp_host_seq_pkg: sequencer states and strobe-pair encodings shared by the host sequencer files.
package spp_host_seq_pkg;
   typedef enum logic [3:0] {
      IDLE, A_LO, A_HI, W_LO, W_HI, R0_LO, R0_HI, R1_LO, R1_HI, DONE
   } sppseq_state;
   // Strobe pairs are {wrextb, rdextb}, both active low.
   localparam logic [1:0] STB_IDLE = 2'b11;
   localparam logic [1:0] STB_ADDR = 2'b00;
   localparam logic [1:0] STB_WR   = 2'b01;
   localparam logic [1:0] STB_RD   = 2'b10;
endpackage

// File: rtl/spp_host_seq_phase_timer.sv
// spp_phase_timer: counts HOLD cycles per strobe phase; expire flags the last cycle of a phase.
module spp_phase_timer #(
   parameter int HOLD = 4
) (
   input  logic clk,
   input  logic rstb,
   input  logic run,
   output logic expire
);
   localparam int W = $clog2(HOLD) + 1;
   logic [W-1:0] cnt_q, cnt_d;
   assign expire = run && (cnt_q == W'(HOLD - 1));
   assign cnt_d  = (!run || expire) ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/spp_host_seq.sv
// spp_host_seq: turns write/read byte commands into the strobe phase sequence of the SRAM
// parallel-port interface and reassembles the two returned read nibbles into a byte.
module spp_host_seq
   import spp_host_seq_pkg::*;
#(
   parameter int HOLD       = 4,
   parameter bit CACHE_ADDR = 1
) (
   input  logic       clk,
   input  logic       rstb,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_wr,
   input  logic [1:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       done,
   output logic [7:0] rsp_data,
   output logic       wrextb,
   output logic       rdextb,
   output logic [7:0] din,
   input  logic [3:0] dout
);
   sppseq_state state_q, state_d;
   logic       wr_q, cache_vld_q, done_q, accept, hit, run, expire;
   logic [1:0] addr_q, addr_d, cache_addr_q, stb_q, stb_d;
   logic [7:0] data_q, data_d, din_q, din_d, rsp_q;
   logic [3:0] lo_q;
   assign cmd_ready = (state_q == IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign hit       = CACHE_ADDR && cache_vld_q && (cmd_addr == cache_addr_q);
   assign run       = (state_q != IDLE) && (state_q != DONE);
   spp_phase_timer #(.HOLD(HOLD)) u_timer (
      .clk    (clk),
      .rstb   (rstb),
      .run    (run),
      .expire (expire)
   );
   always_comb begin
      state_d = state_q;
      addr_d  = accept ? cmd_addr : addr_q;
      data_d  = accept ? cmd_data : data_q;
      case (state_q)
         IDLE:    if (accept) state_d = !hit ? A_LO : cmd_wr ? W_LO : R0_LO;
         A_LO:    if (expire) state_d = A_HI;
         A_HI:    if (expire) state_d = wr_q ? W_LO : R0_LO;
         W_LO:    if (expire) state_d = W_HI;
         W_HI:    if (expire) state_d = DONE;
         R0_LO:   if (expire) state_d = R0_HI;
         R0_HI:   if (expire) state_d = R1_LO;
         R1_LO:   if (expire) state_d = R1_HI;
         R1_HI:   if (expire) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Outputs are decoded from the next state so they are registered alongside it.
      stb_d = (state_d == A_LO) ? STB_ADDR :
              (state_d == W_LO) ? STB_WR :
              (state_d == R0_LO || state_d == R1_LO) ? STB_RD : STB_IDLE;
      din_d = (state_d == A_LO || state_d == A_HI) ? {6'b0, addr_d} :
              (state_d == W_LO || state_d == W_HI) ? data_d : 8'h00;
   end
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q      <= IDLE;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         cache_vld_q  <= 1'b0;
         cache_addr_q <= '0;
         lo_q         <= '0;
         rsp_q        <= '0;
         done_q       <= 1'b0;
         stb_q        <= STB_IDLE;
         din_q        <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= accept ? cmd_wr : wr_q;
         addr_q  <= addr_d;
         data_q  <= data_d;
         stb_q   <= stb_d;
         din_q   <= din_d;
         done_q  <= (state_d == DONE);
         if (state_q == A_HI && expire) begin
            cache_vld_q  <= 1'b1;
            cache_addr_q <= addr_q;
         end
         // The low nibble waits in lo_q so rsp_data only changes when a read completes.
         if (state_q == R1_LO && expire) lo_q <= dout;
         if (state_q == R1_HI && expire) rsp_q <= {dout, lo_q};
      end
   end
   assign wrextb   = stb_q[1];
   assign rdextb   = stb_q[0];
   assign din      = din_q;
   assign done     = done_q;
   assign rsp_data = rsp_q;
endmodule

// File: tb/tb_spp_host_seq.sv
// tb_spp_host_seq: random and directed commands against a phase-schedule model of the sequencer,
// with a small behavioural interface model answering the strobes.
module tb_spp_host_seq;
   localparam int HOLD  = 4;
   localparam bit CACHE = 1;
   localparam int NDIR  = 10;
   localparam int NCMD  = 80;
   localparam int LIMIT = 20000;

   logic clk = 0, rstb = 0;
   always #5 clk = ~clk;

   logic       cmd_valid = 0, cmd_wr = 0;
   logic [1:0] cmd_addr = 0;
   logic [7:0] cmd_data = 0;
   logic [3:0] dout = 0;
   logic       cmd_ready, done, wrextb, rdextb;
   logic [7:0] rsp_data, din;

   spp_host_seq #(.HOLD(HOLD), .CACHE_ADDR(CACHE)) u_dut (
      .clk(clk), .rstb(rstb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .done(done), .rsp_data(rsp_data),
      .wrextb(wrextb), .rdextb(rdextb), .din(din), .dout(dout)
   );

   logic       cmd_valid2 = 0, cmd_wr2 = 0;
   logic [1:0] cmd_addr2 = 0;
   logic [7:0] cmd_data2 = 0;
   logic [3:0] dout2 = 0;
   logic       cmd_ready2, done2, wrextb2, rdextb2;
   logic [7:0] rsp_data2, din2;

   spp_host_seq #(.HOLD(6), .CACHE_ADDR(0)) u_dut6 (
      .clk(clk), .rstb(rstb), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_wr(cmd_wr2),
      .cmd_addr(cmd_addr2), .cmd_data(cmd_data2), .done(done2), .rsp_data(rsp_data2),
      .wrextb(wrextb2), .rdextb(rdextb2), .din(din2), .dout(dout2)
   );

   int errors = 0, checks = 0;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Interface model: latches the address on a both-low strobe, stores bytes on a write strobe,
   // and presents the low then high nibble after the first and second read strobes.
   logic [7:0] mem_if [4] = '{default: 8'h00};
   logic [1:0] ia = 0;
   int         nib = 0;
   logic       prev_r = 1, prev_w = 1;
   always @(negedge clk) begin
      if (!wrextb && !rdextb) ia = din[1:0];
      else if (!wrextb) mem_if[ia] = din;
      if (!prev_r && prev_w && rdextb) nib = (nib == 1) ? 2 : 1;
      else if (prev_r && !rdextb && nib == 2) nib = 0;
      prev_r = rdextb;
      prev_w = wrextb;
      dout = (nib == 1) ? mem_if[ia][3:0] : (nib == 2) ? mem_if[ia][7:4] : 4'($urandom);
   end

   // Reference model: each accepted command expands into its list of HOLD-cycle phases.
   typedef struct {
      logic w, r, dn, upd, mw;
      logic [7:0] d, rsp, md;
      logic [1:0] ma;
   } exp_t;
   exp_t       q[$];
   logic [7:0] mem_ref [4] = '{default: 8'h00};
   logic       cvld = 0;
   logic [1:0] caddr = 0;
   logic [7:0] rsp_exp = 0;

   logic       dwr  [NDIR] = '{1, 1, 1, 0, 0, 0, 1, 1, 0, 0};
   logic [1:0] dad  [NDIR] = '{1, 1, 2, 1, 2, 2, 0, 3, 0, 3};
   logic [7:0] ddat [NDIR] = '{8'h11, 8'h5A, 8'hA5, 0, 0, 0, 8'h3C, 8'hF0, 0, 0};
   int         dlat [NDIR] = '{0, 17, 17, 25, 25, 17, 17, 17, 25, 25};
   logic [7:0] drsp [NDIR] = '{0, 0, 0, 8'h5A, 8'hA5, 8'hA5, 0, 0, 8'h3C, 8'hF0};

   int cyc = 0, acc_cyc = 0, cur = 0, nissued = 0, ndone = 0, lat = 0;
   bit aborted = 0, idle = 1, both = 0;

   task automatic push_phase(logic w, logic r, logic [7:0] d);
      exp_t e;
      e.w = w; e.r = r; e.d = d; e.dn = 0; e.upd = 0; e.mw = 0; e.rsp = 0; e.md = 0; e.ma = 0;
      repeat (HOLD) q.push_back(e);
   endtask

   task automatic schedule(logic wr, logic [1:0] a, logic [7:0] d);
      exp_t e;
      if (!(CACHE && cvld && caddr == a)) begin
         push_phase(0, 0, {6'b0, a});
         push_phase(1, 1, {6'b0, a});
         cvld = 1;
         caddr = a;
      end
      if (wr) begin
         push_phase(0, 1, d);
         push_phase(1, 1, d);
      end else begin
         push_phase(1, 0, 0);
         push_phase(1, 1, 0);
         push_phase(1, 0, 0);
         push_phase(1, 1, 0);
      end
      e.w = 1; e.r = 1; e.d = 0; e.dn = 1; e.upd = !wr; e.rsp = mem_ref[a];
      e.mw = wr; e.md = d; e.ma = a;
      q.push_back(e);
   endtask

   task automatic cycle_check();
      exp_t e;
      idle = (q.size() == 0);
      if (idle) begin
         e.w = 1; e.r = 1; e.d = 0; e.dn = 0; e.upd = 0; e.mw = 0; e.rsp = 0; e.md = 0; e.ma = 0;
      end else e = q.pop_front();
      if (e.dn && e.upd) rsp_exp = e.rsp;
      if (e.dn && e.mw) mem_ref[e.ma] = e.md;
      chk("cmd_ready", cmd_ready, idle);
      chk("wrextb", wrextb, e.w);
      chk("rdextb", rdextb, e.r);
      chk("din", din, e.d);
      chk("done", done, e.dn);
      chk("rsp_data", rsp_data, rsp_exp);
      if (done) begin
         lat = cyc - acc_cyc;
         ndone++;
         if (cur > 0 && cur < NDIR) begin
            chk($sformatf("latency cmd%0d", cur), lat, dlat[cur]);
            if (!dwr[cur]) chk($sformatf("read byte cmd%0d", cur), rsp_data, drsp[cur]);
         end
      end
   endtask

   task automatic present(logic wr, logic [1:0] a, logic [7:0] d);
      cmd_valid = 1; cmd_wr = wr; cmd_addr = a; cmd_data = d;
      schedule(wr, a, d);
      acc_cyc = cyc;
      cur = nissued;
      nissued++;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset wrextb", wrextb, 1);
      chk("reset rdextb", rdextb, 1);
      chk("reset din", din, 0);
      chk("reset done", done, 0);
      chk("reset rsp_data", rsp_data, 0);
      chk("reset cmd_ready", cmd_ready, 1);
      rstb = 1;
      while (cyc < LIMIT && (nissued < NCMD || q.size() != 0)) begin
         @(negedge clk);
         cyc++;
         cycle_check();
         if (nissued == 1 && !aborted && cyc == acc_cyc + 2) begin
            // Abort the first write in the middle of its address phase.
            #1 rstb = 0;
            cmd_valid = 0;
            #1;
            chk("abort wrextb", wrextb, 1);
            chk("abort rdextb", rdextb, 1);
            chk("abort din", din, 0);
            chk("abort cmd_ready", cmd_ready, 1);
            chk("abort done", done, 0);
            q.delete();
            cvld = 0;
            rsp_exp = 0;
            aborted = 1;
            @(negedge clk);
            cyc++;
            rstb = 1;
            continue;
         end
         if (idle && nissued < NDIR) present(dwr[nissued], dad[nissued], ddat[nissued]);
         else if (idle && nissued < NCMD && $urandom_range(3) != 0)
            present(1'($urandom), 2'($urandom), 8'($urandom));
         else begin
            // Noise while busy or idling: must never be latched.
            cmd_valid = idle ? 1'b0 : 1'($urandom);
            cmd_wr = 1'($urandom);
            cmd_addr = 2'($urandom);
            cmd_data = 8'($urandom);
         end
      end
      cmd_valid = 0;
      chk("main loop within cycle budget", cyc < LIMIT, 1);
      chk("commands completed", ndone, NCMD - 1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         cmd_valid2 = 1; cmd_wr2 = 0; cmd_addr2 = 1; cmd_data2 = 8'($urandom);
         @(negedge clk);
         cmd_valid2 = 0;
         lat = 1;
         both = 0;
         while (!done2 && lat < 100) begin
            if (!wrextb2 && !rdextb2) both = 1;
            @(negedge clk);
            lat++;
         end
         chk($sformatf("hold6 latency %0d", k), lat, 37);
         chk($sformatf("hold6 rsp_data %0d", k), rsp_data2, 0);
         chk($sformatf("hold6 address phase %0d", k), both, 1);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
